// File: rtl/combo_lock_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_seq_fsm
// Function : Digit-serial combination lock with in-field reprogramming and
//            timed lockout after repeated failed attempts.
// Revision : 1.0 - initial release
// ============================================================================
module combo_lock_seq_fsm #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_ERR        = 3,
    parameter int LOCKOUT_CYCLES = 100_000_000,
    localparam int ERR_W = $clog2(MAX_ERR + 1),
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter,
    input  logic               lock,
    input  logic               prog,
    output logic [1:0]         state,
    output logic [ERR_W-1:0]   err_count,
    output logic [IDX_W-1:0]   digit_idx,
    output logic               code_ok
);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'b00,
        S_UNLOCKED = 2'b01,
        S_PROGRAM  = 2'b10,
        S_LOCKOUT  = 2'b11
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ERR_W-1:0] c_ERR_LAST = ERR_W'(MAX_ERR - 1);
    localparam logic [ERR_W-1:0] c_ERR_MAX  = ERR_W'(MAX_ERR);
    localparam logic [TMR_W-1:0] c_TMR_LOAD = TMR_W'(LOCKOUT_CYCLES);

    state_t                               state_q, state_d;
    logic [ERR_W-1:0]                     err_q, err_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic                                 code_ok_q, code_ok_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   code_q, code_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   shadow_q, shadow_d;
    logic                                 mism_q, mism_d;
    logic [TMR_W-1:0]                     tmr_q, tmr_d;

    // Digit 0 lives in the most significant slot of the packed code word.
    logic [IDX_W-1:0] w_sel;
    logic             w_last;
    logic             w_digit_bad;

    assign w_sel       = c_LAST_IDX - idx_q;
    assign w_last      = (idx_q == c_LAST_IDX);
    assign w_digit_bad = (digit_in != code_q[w_sel]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOCKED;
            err_q     <= '0;
            idx_q     <= '0;
            code_ok_q <= 1'b0;
            code_q    <= DEFAULT_CODE;
            shadow_q  <= DEFAULT_CODE;
            mism_q    <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            code_ok_q <= code_ok_d;
            code_q    <= code_d;
            shadow_q  <= shadow_d;
            mism_q    <= mism_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        idx_d     = idx_q;
        code_ok_d = 1'b0;
        code_d    = code_q;
        shadow_d  = shadow_q;
        mism_d    = mism_q;
        tmr_d     = tmr_q;

        case (state_q)
            S_LOCKED: begin
                if (lock) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                end else if (enter) begin
                    if (w_last) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!(mism_q || w_digit_bad)) begin
                            state_d   = S_UNLOCKED;
                            err_d     = '0;
                            code_ok_d = 1'b1;
                        end else if (err_q == c_ERR_LAST) begin
                            state_d = S_LOCKOUT;
                            err_d   = c_ERR_MAX;
                            tmr_d   = c_TMR_LOAD;
                        end else begin
                            err_d = err_q + ERR_W'(1);
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        mism_d = mism_q | w_digit_bad;
                    end
                end
            end
            S_UNLOCKED: begin
                if (lock) begin
                    state_d = S_LOCKED;
                    idx_d   = '0;
                end else if (prog) begin
                    state_d = S_PROGRAM;
                    idx_d   = '0;
                end
            end
            S_PROGRAM: begin
                if (lock) begin
                    state_d = S_LOCKED;
                    idx_d   = '0;
                end else if (prog) begin
                    idx_d = '0;
                end else if (enter) begin
                    shadow_d[w_sel] = digit_in;
                    if (w_last) begin
                        code_d  = shadow_d;
                        idx_d   = '0;
                        state_d = S_UNLOCKED;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_LOCKOUT: begin
                // Leave on the edge after the timer shows 1 so the stay is exactly the load value.
                if (tmr_q <= TMR_W'(1)) begin
                    state_d = S_LOCKED;
                    err_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    assign state     = state_q;
    assign err_count = err_q;
    assign digit_idx = idx_q;
    assign code_ok   = code_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_combo_lock_seq_fsm
// Function : Directed self-checking bench for combo_lock_seq_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combo_lock_seq_fsm;

    localparam logic [1:0] c_LCK = 2'b00;
    localparam logic [1:0] c_UNL = 2'b01;
    localparam logic [1:0] c_PRG = 2'b10;
    localparam logic [1:0] c_LKO = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       enter, lock, prog;
    logic [1:0] state, err_count, digit_idx;
    logic       code_ok;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [1:0] er;
        logic [1:0] ix;
        logic       ok;
    } exp_t;
    exp_t sb[$];

    combo_lock_seq_fsm #(
        .DIGIT_W        (4),
        .NUM_DIGITS     (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_ERR        (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .enter     (enter),
        .lock      (lock),
        .prog      (prog),
        .state     (state),
        .err_count (err_count),
        .digit_idx (digit_idx),
        .code_ok   (code_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] es, input logic [1:0] ee,
                             input logic [1:0] ei, input logic eo);
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_err"}, 32'(err_count), 32'(ee));
        chk({tag, "_idx"}, 32'(digit_idx), 32'(ei));
        chk({tag, "_ok"}, 32'(code_ok), 32'(eo));
    endtask

    // One clock of stimulus; the expectation is queued with it and retired after the edge.
    task automatic cyc(input logic en, input logic lk, input logic pg, input logic [3:0] d,
                       input string tag, input logic [1:0] es, input logic [1:0] ee,
                       input logic [1:0] ei, input logic eo);
        exp_t e;
        @(negedge clk);
        enter = en; lock = lk; prog = pg; digit_in = d;
        sb.push_back('{tag, es, ee, ei, eo});
        @(posedge clk);
        #1;
        enter = 1'b0; lock = 1'b0; prog = 1'b0;
        e = sb.pop_front();
        check_all(e.tag, e.st, e.er, e.ix, e.ok);
    endtask

    task automatic attempt(input logic [15:0] c, input logic [1:0] st0, input logic [1:0] err0,
                           input logic [1:0] es, input logic [1:0] ee, input logic eo,
                           input string tag);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b0, c[15-4*i -: 4], tag, st0, err0, 2'(i + 1), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, c[3:0], {tag, "_last"}, es, ee, 2'b00, eo);
    endtask

    task automatic async_rst(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all(tag, c_LCK, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enter = 1'b0; lock = 1'b0; prog = 1'b0; digit_in = 4'h0;
        #2;
        check_all("reset", c_LCK, 2'd0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        attempt(16'h1234, c_LCK, 2'd0, c_UNL, 2'd0, 1'b1, "ok1");
        cyc(0, 0, 0, 4'h0, "ok1_pulse_end", c_UNL, 2'd0, 2'd0, 1'b0);
        cyc(1, 0, 0, 4'h5, "unl_enter", c_UNL, 2'd0, 2'd0, 1'b0);
        cyc(0, 1, 0, 4'h0, "relock1", c_LCK, 2'd0, 2'd0, 1'b0);

        attempt(16'h1235, c_LCK, 2'd0, c_LCK, 2'd1, 1'b0, "bad1");
        attempt(16'h1235, c_LCK, 2'd1, c_LCK, 2'd2, 1'b0, "bad2");
        attempt(16'h1235, c_LCK, 2'd2, c_LKO, 2'd3, 1'b0, "bad3");
        for (int i = 1; i < 16; i++)
            cyc(1'(i % 2), 1'(i == 6), 1'(i == 9), 4'h1, "lockout", c_LKO, 2'd3, 2'd0, 1'b0);
        cyc(0, 0, 0, 4'h0, "lockout_end", c_LCK, 2'd0, 2'd0, 1'b0);

        attempt(16'h1235, c_LCK, 2'd0, c_LCK, 2'd1, 1'b0, "bad4");
        cyc(1, 0, 0, 4'h1, "abort_d1", c_LCK, 2'd1, 2'd1, 1'b0);
        cyc(1, 0, 0, 4'h2, "abort_d2", c_LCK, 2'd1, 2'd2, 1'b0);
        cyc(0, 1, 0, 4'h0, "abort_lock", c_LCK, 2'd1, 2'd0, 1'b0);
        attempt(16'h1234, c_LCK, 2'd1, c_UNL, 2'd0, 1'b1, "ok2");

        cyc(0, 0, 1, 4'h0, "prog1", c_PRG, 2'd0, 2'd0, 1'b0);
        cyc(1, 0, 0, 4'h5, "prog_d1", c_PRG, 2'd0, 2'd1, 1'b0);
        cyc(1, 0, 0, 4'h5, "prog_d2", c_PRG, 2'd0, 2'd2, 1'b0);
        cyc(0, 1, 0, 4'h0, "prog_abort", c_LCK, 2'd0, 2'd0, 1'b0);
        attempt(16'h1234, c_LCK, 2'd0, c_UNL, 2'd0, 1'b1, "ok3");

        cyc(0, 1, 0, 4'h0, "relock2", c_LCK, 2'd0, 2'd0, 1'b0);
        cyc(1, 0, 0, 4'h1, "sim_d1", c_LCK, 2'd0, 2'd1, 1'b0);
        cyc(1, 0, 0, 4'h2, "sim_d2", c_LCK, 2'd0, 2'd2, 1'b0);
        cyc(1, 0, 0, 4'h3, "sim_d3", c_LCK, 2'd0, 2'd3, 1'b0);
        cyc(1, 1, 0, 4'h4, "sim_enter_lock", c_LCK, 2'd0, 2'd0, 1'b0);
        attempt(16'h1234, c_LCK, 2'd0, c_UNL, 2'd0, 1'b1, "ok4");

        cyc(0, 0, 1, 4'h0, "prog2", c_PRG, 2'd0, 2'd0, 1'b0);
        attempt(16'h9876, c_PRG, 2'd0, c_UNL, 2'd0, 1'b0, "newcode");
        cyc(0, 1, 0, 4'h0, "relock3", c_LCK, 2'd0, 2'd0, 1'b0);
        attempt(16'h1234, c_LCK, 2'd0, c_LCK, 2'd1, 1'b0, "old_code_bad");
        attempt(16'h9876, c_LCK, 2'd1, c_UNL, 2'd0, 1'b1, "new_code_ok");
        cyc(0, 1, 1, 4'h0, "lock_prog", c_LCK, 2'd0, 2'd0, 1'b0);

        attempt(16'h1234, c_LCK, 2'd0, c_LCK, 2'd1, 1'b0, "bad5");
        attempt(16'h1234, c_LCK, 2'd1, c_LCK, 2'd2, 1'b0, "bad6");
        attempt(16'h1234, c_LCK, 2'd2, c_LKO, 2'd3, 1'b0, "bad7");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 4'h0, "lockout2", c_LKO, 2'd3, 2'd0, 1'b0);
        async_rst("rst_in_lockout");
        attempt(16'h1234, c_LCK, 2'd0, c_UNL, 2'd0, 1'b1, "ok_after_rst1");

        cyc(0, 0, 1, 4'h0, "prog3", c_PRG, 2'd0, 2'd0, 1'b0);
        attempt(16'h9876, c_PRG, 2'd0, c_UNL, 2'd0, 1'b0, "newcode2");
        async_rst("rst_after_prog");
        attempt(16'h1234, c_LCK, 2'd0, c_UNL, 2'd0, 1'b1, "ok_after_rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
